// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Widest value neg2c handles; callers zero-extend in and cast the result back down.
  localparam int unsigned MAX_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  function automatic logic [MAX_W-1:0] neg2c(input logic [MAX_W-1:0] v);
    return ~v + MAX_W'(1);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // When the subtraction succeeds the result is below the divisor, so W bits suffice.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted[WIDTH-1:0] - divisor_i;
    qbit_o  = (shifted >= {1'b0, divisor_i});
    rem_o   = qbit_o ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Sequential signed/unsigned multiply (shift-add) and divide (restoring) with HI/LO results.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  state_e               state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic                 dz_q, dz_d;
  logic                 res_neg_q, res_neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;

  logic                 signed_op, div_op;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH-1:0]     step_rem;
  logic                 step_qbit;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
    .bit_i     (acc_q[WIDTH-1]),
    .divisor_i (opb_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    state_d    = state_q;
    is_div_d   = is_div_q;
    dz_d       = dz_q;
    res_neg_d  = res_neg_q;
    rem_neg_d  = rem_neg_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    signed_op = (op == OP_MULT) || (op == OP_DIV);
    div_op    = (op == OP_DIV)  || (op == OP_DIVU);
    a_mag = (signed_op && a[WIDTH-1]) ? WIDTH'(neg2c(MAX_W'(a))) : a;
    b_mag = (signed_op && b[WIDTH-1]) ? WIDTH'(neg2c(MAX_W'(b))) : b;
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d   = div_op;
          opb_d      = b_mag;
          acc_d      = {{WIDTH{1'b0}}, a_mag};
          cnt_d      = '0;
          div_zero_d = 1'b0;
          res_neg_d  = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
          rem_neg_d  = signed_op && a[WIDTH-1];
          dz_d       = div_op && (b == '0);
          if (div_op && (b == '0)) begin
            // Raw dividend parked in the upper half is returned unchanged as HI.
            acc_d   = {a, {WIDTH{1'b0}}};
            state_d = FIX;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (is_div_q) acc_d = {step_rem, acc_q[WIDTH-2:0], step_qbit};
        else          acc_d = {add_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (dz_q) begin
          hi_d = acc_q[2*WIDTH-1:WIDTH];
          lo_d = '1;
        end else if (is_div_q) begin
          lo_d = res_neg_q ? WIDTH'(neg2c(MAX_W'(acc_q[WIDTH-1:0]))) : acc_q[WIDTH-1:0];
          hi_d = rem_neg_q ? WIDTH'(neg2c(MAX_W'(acc_q[2*WIDTH-1:WIDTH])))
                           : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = res_neg_q ? (2*WIDTH)'(neg2c(MAX_W'(acc_q))) : acc_q;
        end
        div_zero_d = dz_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      opb_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      dz_q       <= dz_d;
      res_neg_q  <= res_neg_d;
      rem_neg_q  <= rem_neg_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        start32 = 1'b0;
  logic [1:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clock(clock), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_zero(dz32)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one request; returns after the accept edge with start released.
  task automatic issue32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    op32 = o; a32 = x; b32 = y; start32 = 1'b1;
    @(posedge clock); #1;
    start32 = 1'b0;
  endtask

  // lat counts edges from the accept edge (=1) to the edge after which done is high.
  task automatic wait_done32(output int lat, output int busy_n);
    lat = 1; busy_n = 0;
    while (!done32 && lat < 100) begin
      if (busy32) busy_n++;
      @(posedge clock); #1;
      lat++;
    end
    check("done_seen", 64'(done32), 64'd1);
    check("busy_in_done", 64'(busy32), 64'd0);
  endtask

  task automatic op32_full(input string tag, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                           input int elat);
    int lat, bn;
    issue32(o, x, y);
    check({tag, "_accept"}, 64'(busy32), 64'd1);
    wait_done32(lat, bn);
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_hi"}, 64'(hi32), 64'(ehi));
    check({tag, "_lo"}, 64'(lo32), 64'(elo));
  endtask

  initial begin
    int lat, bn, saw;

    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_done", 64'(done32), 64'd0);
    check("rst_hi", 64'(hi32), 64'd0);
    check("rst_lo", 64'(lo32), 64'd0);
    check("rst_dz", 64'(dz32), 64'd0);
    check("rst8_hilo", {48'd0, hi8, lo8}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Signed multiply with full latency and busy-width measurement.
    issue32(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done32(lat, bn);
    check("mult_neg_lat", 64'(lat), 64'd34);
    check("mult_neg_busy", 64'(bn), 64'd33);
    check("mult_neg_hi", 64'(hi32), 64'hFFFF_FFFF);
    check("mult_neg_lo", 64'(lo32), 64'hFFFF_FFEB);

    op32_full("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 34);
    op32_full("mult_m1sq", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 34);
    op32_full("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 34);

    op32_full("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
    op32_full("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34);
    op32_full("divu_7_2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 34);
    op32_full("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34);
    check("div_min_m1_dz", 64'(dz32), 64'd0);

    // Divide by zero, then a multiply clears the flag on accept.
    op32_full("divu_zero", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 2);
    check("divu_zero_flag", 64'(dz32), 64'd1);
    issue32(OP_MULT, 32'd6, 32'd7);
    check("dz_clear", 64'(dz32), 64'd0);
    wait_done32(lat, bn);
    check("after_dz_lo", 64'(lo32), 64'd42);

    // Start while busy is ignored.
    issue32(OP_MULTU, 32'd11, 32'd13);
    repeat (5) @(posedge clock);
    @(negedge clock);
    op32 = OP_DIVU; a32 = 32'd9; b32 = 32'd3; start32 = 1'b1;
    @(posedge clock); #1;
    start32 = 1'b0;
    wait_done32(lat, bn);
    check("midcalc_hi", 64'(hi32), 64'd0);
    check("midcalc_lo", 64'(lo32), 64'd143);

    // Back-to-back: the next issue drives start during the done cycle.
    op32_full("b2b_a", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34);
    op32_full("b2b_b", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 34);

    // Reset mid-divide aborts with no done.
    issue32(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_busy", 64'(busy32), 64'd0);
    check("abort_done", 64'(done32), 64'd0);
    check("abort_hilo", {hi32, lo32}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    saw = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done32) saw = 1;
    end
    check("abort_no_done", 64'(saw), 64'd0);
    op32_full("post_rst", OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 34);

    // Narrow instance: signed most-negative squared.
    @(negedge clock);
    op8 = OP_MULT; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    check("w8_lat", 64'(lat), 64'd10);
    check("w8_hi", 64'(hi8), 64'h40);
    check("w8_lo", 64'(lo8), 64'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
